// File: rtl/config_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module      : config_chain_loader
//  Description : Serial configuration-chain sequencer for one fabric tile.
//                Accepts words over valid/ready, shifts CHAIN_LEN bits
//                LSB-first onto shift_in with cen, then pulses cset once.
//                Optional CRC-16-CCITT of the shifted stream, enabled by
//                defining CONFIG_LOADER_CRC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module config_chain_loader #(
    parameter int CHAIN_LEN = 1164,
    parameter int WORD_W    = 32
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active-low
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cen,
    output logic              shift_in,
    output logic              cset,
    output logic              busy,
    output logic              done,
    output logic [15:0]       crc
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W  = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0] c_chain_len  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] c_chain_last = CNT_W'(CHAIN_LEN - 1);
    localparam logic [31:0]      c_word_w32   = 32'(WORD_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SHIFT = 3'd2,
        S_LATCH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WORD_W-1:0]  r_sreg;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [WB_W-1:0]    r_word_bits;
    logic               r_shift_hold;
    logic [CNT_W-1:0]   w_remaining;
    logic [WB_W-1:0]    w_load_bits;
    logic               w_begin;

    assign w_begin     = (r_state == S_IDLE) && start && !abort;
    assign w_remaining = c_chain_len - r_bit_cnt;
    // The final word may be partial: only the bits still needed are shifted.
    assign w_load_bits = (32'(w_remaining) >= c_word_w32) ? WB_W'(WORD_W)
                                                          : WB_W'(w_remaining);

    // shift_in follows the shift register while shifting, otherwise holds.
    assign shift_in = (r_state == S_SHIFT) ? r_sreg[0] : r_shift_hold;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state and control outputs; abort wins over any handshake.
    always_comb begin
        w_state_nxt = r_state;
        word_ready  = 1'b0;
        cen         = 1'b0;
        cset        = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && !abort) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                word_ready = 1'b1;
                if (abort)           w_state_nxt = S_IDLE;
                else if (word_valid) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                cen = 1'b1;
                if (abort)
                    w_state_nxt = S_IDLE;
                else if (r_word_bits == WB_W'(1))
                    w_state_nxt = (r_bit_cnt == c_chain_last) ? S_LATCH : S_FETCH;
            end
            S_LATCH: begin
                cset        = !abort;
                w_state_nxt = abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Shift datapath: word load, bit serialisation and progress counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sreg       <= '0;
            r_bit_cnt    <= '0;
            r_word_bits  <= '0;
            r_shift_hold <= 1'b0;
        end else begin
            if (w_begin) begin
                r_bit_cnt <= '0;
            end
            if ((r_state == S_FETCH) && word_valid && !abort) begin
                r_sreg      <= word_data;
                r_word_bits <= w_load_bits;
            end
            if (r_state == S_SHIFT) begin
                r_sreg       <= r_sreg >> 1;
                r_bit_cnt    <= r_bit_cnt + CNT_W'(1);
                r_word_bits  <= r_word_bits - WB_W'(1);
                r_shift_hold <= r_sreg[0];
            end
        end
    end

`ifdef CONFIG_LOADER_CRC_EN
    logic [15:0] r_crc;
    logic        w_crc_fb;

    assign w_crc_fb = r_crc[15] ^ r_sreg[0];
    assign crc      = r_crc;

    // CRC-16-CCITT (0x1021), MSB-first over the shifted bits; seeded on start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_crc <= 16'h0000;
        end else if (w_begin) begin
            r_crc <= 16'hFFFF;
        end else if (r_state == S_SHIFT) begin
            r_crc <= {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);
        end
    end
`else
    assign crc = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_config_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_config_chain_loader
//  Description : Self-checking bench for config_chain_loader (CHAIN_LEN=40,
//                WORD_W=16) against a stream-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_config_chain_loader;

    localparam int CHAIN_LEN = 40;
    localparam int WORD_W    = 16;
    localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [WORD_W-1:0] word_data = '0;
    logic              word_valid = 1'b0;
    logic              word_ready;
    logic              cen;
    logic              shift_in;
    logic              cset;
    logic              busy;
    logic              done;
    logic [15:0]       crc;

    int n_checks = 0;
    int n_fails  = 0;

    logic [WORD_W-1:0] words [NW];

    config_chain_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .cen        (cen),
        .shift_in   (shift_in),
        .cset       (cset),
        .busy       (busy),
        .done       (done),
        .crc        (crc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: the chain receives word bits in order, LSB first, truncated.
    function automatic logic [63:0] model_bits();
        logic [63:0] v = '0;
        for (int i = 0; i < CHAIN_LEN; i++) v[i] = words[i / WORD_W][i % WORD_W];
        return v;
    endfunction

    function automatic logic [15:0] model_crc(input logic [63:0] v);
        logic [15:0] c = 16'hFFFF;
        logic        fb;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            fb = c[15] ^ v[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    function automatic logic want_valid(input int idx, input int sw, input int scnt, input int slen);
        return (idx < NW) && !((idx == sw) && (scnt < slen));
    endfunction

    // One load: start in cycle 0; cycle k is observed at the negedge after the
    // k-th following rising edge. Optional stall, abort, reset and a stray start.
    task automatic run_load(input int stall_word, input int stall_len,
                            input int abort_k, input int rst_k, input int restart_k);
        int idx = 0, scnt = 0, cen_cnt = 0, bubble_cnt = 0, busy_cnt = 0;
        int cset_cnt = 0, cset_k = -1, done_cnt = 0, done_k = -1;
        int exp_cset, budget;
        logic [63:0] obs_bits = '0;
        logic [63:0] exp_bits;
        logic [15:0] crc_done = '0;

        exp_cset = 1 + NW + CHAIN_LEN + stall_len;
        budget   = exp_cset + 4;

        @(posedge clk); #1;
        start      = 1'b1;
        abort      = 1'b0;
        word_valid = want_valid(idx, stall_word, scnt, stall_len);
        word_data  = words[0];

        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            start      = (k == restart_k);
            abort      = (k == abort_k);
            word_valid = want_valid(idx, stall_word, scnt, stall_len);
            word_data  = (idx < NW) ? words[idx] : WORD_W'($urandom);
            if (k == rst_k) begin
                rst = 1'b0;
                #1;
                check_eq("rst_cen",   64'(cen),        64'd0);
                check_eq("rst_cset",  64'(cset),       64'd0);
                check_eq("rst_busy",  64'(busy),       64'd0);
                check_eq("rst_ready", 64'(word_ready), 64'd0);
                check_eq("rst_sin",   64'(shift_in),   64'd0);
                check_eq("rst_done",  64'(done),       64'd0);
                check_eq("rst_crc",   64'(crc),        64'd0);
                start = 1'b0; abort = 1'b0; word_valid = 1'b0;
                @(posedge clk); #1;
                rst = 1'b1;
                return;
            end
            @(negedge clk);
            if (word_ready && word_valid) idx++;
            else if (word_ready && (idx == stall_word) && (scnt < stall_len)) begin
                scnt++;
                check_eq("stall_cen", 64'(cen), 64'd0);
            end
            if (cen) begin
                if (cen_cnt < 64) obs_bits[cen_cnt] = shift_in;
                cen_cnt++;
            end else if (busy && !cset && !done) begin
                bubble_cnt++;
            end
            if (busy) busy_cnt++;
            if (cset) begin cset_cnt++; cset_k = k; end
            if (done) begin done_cnt++; done_k = k; crc_done = crc; end
            if ((abort_k > 0) && (k == abort_k + 1)) check_eq("abort_busy", 64'(busy), 64'd0);
        end
        start = 1'b0; abort = 1'b0; word_valid = 1'b0;

        if (abort_k > 0) begin
            check_eq("abort_cset_cnt", 64'(cset_cnt), 64'd0);
            check_eq("abort_done_cnt", 64'(done_cnt), 64'd0);
            return;
        end

        exp_bits = model_bits();
        check_eq("cset_cnt",   64'(cset_cnt),   64'd1);
        check_eq("cset_cycle", 64'(cset_k),     64'(exp_cset));
        check_eq("done_cnt",   64'(done_cnt),   64'd1);
        check_eq("done_cycle", 64'(done_k),     64'(exp_cset + 1));
        check_eq("cen_cnt",    64'(cen_cnt),    64'(CHAIN_LEN));
        check_eq("bubbles",    64'(bubble_cnt), 64'(NW + stall_len));
        check_eq("busy_cnt",   64'(busy_cnt),   64'(exp_cset + 1));
        check_eq("words_used", 64'(idx),        64'(NW));
        check_eq("bits",       obs_bits,        exp_bits);
`ifdef CONFIG_LOADER_CRC_EN
        check_eq("crc_done",   64'(crc_done),   64'(model_crc(exp_bits)));
        check_eq("crc_hold",   64'(crc),        64'(model_crc(exp_bits)));
`else
        check_eq("crc_done",   64'(crc_done),   64'd0);
        check_eq("crc_hold",   64'(crc),        64'd0);
`endif
    endtask

    task automatic randomise_words();
        for (int i = 0; i < NW; i++) words[i] = WORD_W'($urandom);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_busy",  64'(busy),       64'd0);
        check_eq("reset_cen",   64'(cen),        64'd0);
        check_eq("reset_cset",  64'(cset),       64'd0);
        check_eq("reset_ready", 64'(word_ready), 64'd0);
        check_eq("reset_done",  64'(done),       64'd0);
        check_eq("reset_crc",   64'(crc),        64'd0);
        rst = 1'b1;

        // Directed words; the upper byte of the last word must never shift.
        words[0] = 16'hA5A5; words[1] = 16'h0F0F; words[2] = 16'hFFC3;
        run_load(-1, 0, 0, 0, 0);

        // Five-cycle valid gap before word 2, plus a start while busy.
        randomise_words();
        run_load(2, 5, 0, 0, 10);

        // Abort in the middle of shifting word 1, then a clean load.
        randomise_words();
        run_load(-1, 0, 24, 0, 0);
        randomise_words();
        run_load(-1, 0, 0, 0, 0);

        // start and abort together in IDLE: stays idle.
        @(posedge clk); #1; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check_eq("start_abort_busy",  64'(busy),       64'd0);
        check_eq("start_abort_ready", 64'(word_ready), 64'd0);

        // Asynchronous reset during SHIFT, then a full load.
        randomise_words();
        run_load(-1, 0, 0, 8, 0);
        randomise_words();
        run_load(-1, 0, 0, 0, 0);

        // All-zero chain and random loads with random gaps.
        for (int i = 0; i < NW; i++) words[i] = '0;
        run_load(-1, 0, 0, 0, 0);
        for (int r = 0; r < 6; r++) begin
            randomise_words();
            run_load(int'($urandom_range(0, NW - 1)), int'($urandom_range(0, 6)), 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
